lcd_hd44780_responder: RTL and testbench

Behavioural/synthesizable model of the HD44780 character-LCD controller side of the 4-bit parallel LCD bus that the PIC core drives through PORTB (D7..D4, RS, RW, EN). It decodes bus cycles into complete command/data bytes and maintains the address counter and busy flag. It answers busy-flag/address reads so firmware handshakes can be exercised in simulation and on-chip without a physical display. It sits on the far side of the port pins, alongside `fake_bidir_port` instances in top-levels and testbenches.

---
 rtl/lcd_hd44780_responder.sv | 135 +++++++++++++
 tb/tb_lcd_hd44780_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_responder.sv
// HD44780 controller-side responder for the 4-bit LCD bus: assembles written bytes,
// tracks the address counter and busy flag, and answers busy-flag/address reads.
module lcd_hd44780_responder #(
  parameter int BUSY_CYCLES      = 2000,
  parameter int BUSY_CYCLES_LONG = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_en,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [3:0] lcd_data_in,
  output logic [3:0] lcd_data_out,
  output logic       lcd_data_oe,
  output logic       byte_valid,
  output logic       byte_rs,
  output logic [7:0] byte_data,
  output logic [6:0] byte_addr,
  output logic       busy,
  output logic       four_bit_mode,
  output logic       overrun
);

  typedef enum logic [1:0] {MODE8, MODE4_HI, MODE4_LO} state_t;

  state_t      state, state_next;
  logic [2:0]  en_sync;
  logic [1:0]  rs_sync, rw_sync;
  logic [3:0]  d_sync1, d_sync2;
  logic [3:0]  hi_nib;
  logic [16:0] busy_cnt;
  logic [6:0]  ac, ac_next;
  logic        inc, inc_next;

  logic        en_s, rs_s, rw_s, en_rise, en_fall;
  logic        wr_fall, complete, accept, is_home;
  logic [7:0]  full_byte;
  logic [3:0]  rd_val;

  assign en_s    = en_sync[1];
  assign rs_s    = rs_sync[1];
  assign rw_s    = rw_sync[1];
  assign en_rise = en_sync[1] & ~en_sync[2];
  assign en_fall = ~en_sync[1] & en_sync[2];

  assign busy          = (busy_cnt != 17'd0);
  assign four_bit_mode = (state != MODE8);

  // A byte completes on every 8-bit-mode write or on the low-nibble write in 4-bit mode.
  assign wr_fall   = en_fall & ~rw_s;
  assign complete  = wr_fall & (state != MODE4_HI);
  assign accept    = complete & ~busy;
  assign full_byte = (state == MODE8) ? {d_sync2, 4'h0} : {hi_nib, d_sync2};
  assign is_home   = ~rs_s & (full_byte[7:2] == 6'd0) & (full_byte[1:0] != 2'd0);
  assign rd_val    = rs_s ? 4'h0 : ((state == MODE4_LO) ? ac[3:0] : {busy, ac[6:4]});

  always_comb begin
    state_next = state;
    if (en_fall) begin
      case (state)
        MODE8:    if (accept && !rs_s && full_byte[7:4] == 4'b0010) state_next = MODE4_HI;
        MODE4_HI: state_next = MODE4_LO;
        MODE4_LO: begin
          if (accept && !rs_s && full_byte[7:4] == 4'b0011) state_next = MODE8;
          else state_next = MODE4_HI;
        end
        default:  state_next = MODE8;
      endcase
    end
  end

  always_comb begin
    ac_next  = ac;
    inc_next = inc;
    if (accept) begin
      if (rs_s) begin
        ac_next = inc ? ac + 7'd1 : ac - 7'd1;
      end else if (full_byte[7]) begin
        ac_next = full_byte[6:0];
      end else if (full_byte[7:2] == 6'b000001) begin
        inc_next = full_byte[1];
      end else if (is_home) begin
        ac_next = 7'd0;
        if (full_byte[1:0] == 2'b01) inc_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      en_sync      <= '0;
      rs_sync      <= '0;
      rw_sync      <= '0;
      d_sync1      <= '0;
      d_sync2      <= '0;
      state        <= MODE8;
      hi_nib       <= '0;
      ac           <= '0;
      inc          <= 1'b1;
      busy_cnt     <= '0;
      overrun      <= 1'b0;
      byte_valid   <= 1'b0;
      byte_rs      <= 1'b0;
      byte_data    <= '0;
      byte_addr    <= '0;
      lcd_data_out <= '0;
      lcd_data_oe  <= 1'b0;
    end else begin
      en_sync    <= {en_sync[1:0], lcd_en};
      rs_sync    <= {rs_sync[0], lcd_rs};
      rw_sync    <= {rw_sync[0], lcd_rw};
      d_sync1    <= lcd_data_in;
      d_sync2    <= d_sync1;
      state      <= state_next;
      ac         <= ac_next;
      inc        <= inc_next;
      byte_valid <= accept;
      if (accept) begin
        byte_rs   <= rs_s;
        byte_data <= full_byte;
        byte_addr <= ac;
        busy_cnt  <= is_home ? 17'(BUSY_CYCLES_LONG) : 17'(BUSY_CYCLES);
      end else if (busy) begin
        busy_cnt <= busy_cnt - 17'd1;
      end
      if (complete && busy) overrun <= 1'b1;
      if (wr_fall && state == MODE4_HI) hi_nib <= d_sync2;
      // Read data is frozen at EN rise so the value is stable for the whole strobe.
      lcd_data_oe <= en_s & rw_s;
      if (en_rise && rw_s) lcd_data_out <= rd_val;
      else if (en_fall) lcd_data_out <= 4'h0;
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Bench for lcd_hd44780_responder: directed bus sequences then random bus cycles,
// all outputs compared every cycle against an event-driven behavioural model.
module tb_lcd_hd44780_responder;
  localparam int BC = 20;
  localparam int BL = 60;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       lcd_en = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
  logic [3:0] lcd_data_in = 4'h0;
  logic [3:0] lcd_data_out;
  logic       lcd_data_oe, byte_valid, byte_rs, busy, four_bit_mode, overrun;
  logic [7:0] byte_data;
  logic [6:0] byte_addr;

  lcd_hd44780_responder #(.BUSY_CYCLES(BC), .BUSY_CYCLES_LONG(BL)) dut (
    .clk(clk), .rst(rst), .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_data_in(lcd_data_in), .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe),
    .byte_valid(byte_valid), .byte_rs(byte_rs), .byte_data(byte_data),
    .byte_addr(byte_addr), .busy(busy), .four_bit_mode(four_bit_mode), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus events take effect at the clock edge where the DUT sees them after synchronization.
  typedef struct {
    int         at;
    int         kind;   // 0 = EN fall, 1 = EN rise, 2 = reset
    logic       rs;
    logic       rw;
    logic [3:0] nib;
  } ev_t;
  ev_t evq[$];

  int         m_mode;   // 0 = 8-bit, 1 = expecting high nibble, 2 = expecting low nibble
  logic [3:0] m_hi;
  logic [6:0] m_ac;
  bit         m_id;
  int         m_busy_end;
  bit         m_ovr;
  int         m_valid_at;
  logic       m_brs;
  logic [7:0] m_bdata;
  logic [6:0] m_baddr;
  bit         m_oe;
  logic [3:0] m_rd;
  bit         checking = 1'b0;

  task automatic model_reset();
    m_mode = 0; m_hi = 4'h0; m_ac = 7'd0; m_id = 1'b1; m_busy_end = 0; m_ovr = 1'b0;
    m_valid_at = -1; m_brs = 1'b0; m_bdata = 8'h00; m_baddr = 7'd0; m_oe = 1'b0; m_rd = 4'h0;
  endtask

  task automatic model_byte(input int e, input logic rs, input logic [7:0] b, input bit bsy);
    if (bsy) begin
      m_ovr = 1'b1;
    end else begin
      m_valid_at = e; m_brs = rs; m_bdata = b; m_baddr = m_ac;
      m_busy_end = e + ((!rs && b >= 8'd1 && b <= 8'd3) ? BL : BC);
      if (rs) m_ac = m_id ? m_ac + 7'd1 : m_ac - 7'd1;
      else if (b >= 8'h80) m_ac = b[6:0];
      else if (b >= 8'd4 && b <= 8'd7) m_id = b[1];
      else if (b >= 8'd1 && b <= 8'd3) begin
        m_ac = 7'd0;
        if (b == 8'd1) m_id = 1'b1;
      end
      if (!rs && m_mode == 0 && b[7:4] == 4'h2) m_mode = 1;
      else if (!rs && m_mode != 0 && b[7:4] == 4'h3) m_mode = 0;
    end
  endtask

  task automatic model_event(input ev_t ev);
    bit bsy;
    bsy = (ev.at <= m_busy_end);
    if (ev.kind == 2) begin
      model_reset();
    end else if (ev.kind == 1) begin
      if (ev.rw) begin
        m_oe = 1'b1;
        m_rd = ev.rs ? 4'h0 : (m_mode == 2 ? m_ac[3:0] : {bsy, m_ac[6:4]});
      end
    end else begin
      m_oe = 1'b0; m_rd = 4'h0;
      if (ev.rw) begin
        if (m_mode == 1) m_mode = 2;
        else if (m_mode == 2) m_mode = 1;
      end else if (m_mode == 0) begin
        model_byte(ev.at, ev.rs, {ev.nib, 4'h0}, bsy);
      end else if (m_mode == 1) begin
        m_hi = ev.nib; m_mode = 2;
      end else begin
        m_mode = 1;
        model_byte(ev.at, ev.rs, {m_hi, ev.nib}, bsy);
      end
    end
  endtask

  ev_t cev;
  always @(negedge clk) begin
    while (evq.size() > 0 && evq[0].at <= cyc) begin
      cev = evq.pop_front();
      model_event(cev);
    end
    if (checking) begin
      check("byte_valid", byte_valid, m_valid_at == cyc);
      check("byte_rs", byte_rs, m_brs);
      check("byte_data", byte_data, m_bdata);
      check("byte_addr", byte_addr, m_baddr);
      check("busy", busy, cyc < m_busy_end);
      check("overrun", overrun, m_ovr);
      check("four_bit_mode", four_bit_mode, m_mode != 0);
      check("lcd_data_oe", lcd_data_oe, m_oe);
      check("lcd_data_out", lcd_data_out, m_rd);
    end
  end

  task automatic push_ev(input int at, input int kind, input logic rs, input logic rw,
                         input logic [3:0] nib);
    ev_t e;
    e.at = at; e.kind = kind; e.rs = rs; e.rw = rw; e.nib = nib;
    evq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic bus_cycle(input logic rs, input logic rw, input logic [3:0] nib,
                           input int hi_cyc, input int lo_cyc,
                           output logic [3:0] rd, output logic oe);
    @(posedge clk); #1;
    lcd_rs = rs; lcd_rw = rw; lcd_data_in = nib; lcd_en = 1'b1;
    push_ev(cyc + 3, 1, rs, rw, nib);
    repeat (hi_cyc) @(posedge clk);
    #1;
    rd = lcd_data_out; oe = lcd_data_oe;
    lcd_en = 1'b0;
    push_ev(cyc + 3, 0, rs, rw, nib);
    repeat (lo_cyc) @(posedge clk);
  endtask

  logic [3:0] rd, rd2;
  logic       oe, oe2;

  task automatic wr_nib(input logic rs, input logic [3:0] nib);
    bus_cycle(rs, 1'b0, nib, 4, 4, rd, oe);
  endtask

  task automatic wr_byte(input logic rs, input logic [7:0] b);
    wr_nib(rs, b[7:4]);
    wr_nib(rs, b[3:0]);
  endtask

  task automatic rd_pair(output logic [3:0] hi, output logic hoe,
                         output logic [3:0] lo, output logic loe);
    bus_cycle(1'b0, 1'b1, 4'h0, 4, 4, hi, hoe);
    bus_cycle(1'b0, 1'b1, 4'h0, 4, 4, lo, loe);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outputs"},
          {lcd_data_out, lcd_data_oe, byte_valid, byte_rs, byte_data, byte_addr,
           busy, four_bit_mode, overrun}, 32'd0);
  endtask

  initial begin
    model_reset();
    idle(2); #1;
    check_all_zero("reset");
    rst = 1'b1;
    checking = 1'b1;

    for (int i = 0; i < 3; i++) begin
      wr_nib(1'b0, 4'h3);
      idle(BC + 5);
      check("init_0x30", byte_data, 8'h30);
    end
    wr_nib(1'b0, 4'h2);
    idle(BC + 5);
    check("init_0x20", byte_data, 8'h20);
    check("four_bit_after_init", four_bit_mode, 1'b1);

    wr_byte(1'b0, 8'h85);
    idle(BC + 5);
    check("cmd_0x85", byte_data, 8'h85);
    check("model_ac_0x05", m_ac, 7'h05);
    wr_byte(1'b1, 8'h41);
    check("data_addr", byte_addr, 7'h05);
    check("data_rs", byte_rs, 1'b1);
    check("busy_after_data", busy, 1'b1);

    rd_pair(rd, oe, rd2, oe2);
    check("rd_busy_hi", rd, 4'h8);
    check("rd_busy_lo", rd2, 4'h6);
    check("rd_oe", {oe, oe2}, 2'b11);
    check("oe_idle", lcd_data_oe, 1'b0);
    idle(BC + 5);
    rd_pair(rd, oe, rd2, oe2);
    check("rd_free_hi", rd, 4'h0);
    check("rd_free_lo", rd2, 4'h6);

    wr_byte(1'b0, 8'hFF);
    idle(BC + 5);
    wr_byte(1'b1, 8'h41);
    idle(BC + 5);
    check("model_ac_wrap_up", m_ac, 7'h00);
    rd_pair(rd, oe, rd2, oe2);
    check("ac_wrap_up", {rd, rd2}, 8'h00);
    wr_byte(1'b0, 8'h04);
    idle(BC + 5);
    wr_byte(1'b1, 8'h41);
    idle(BC + 5);
    rd_pair(rd, oe, rd2, oe2);
    check("ac_wrap_down", {rd, rd2}, 8'h7F);

    wr_byte(1'b0, 8'h01);
    wr_byte(1'b1, 8'h41);
    check("overrun_set", overrun, 1'b1);
    check("discarded_byte", byte_data, 8'h01);
    idle(BL + 5);
    check("busy_long_done", busy, 1'b0);

    wr_nib(1'b0, 4'h2);
    @(posedge clk); #1;
    rst = 1'b0;
    push_ev(cyc + 1, 2, 1'b0, 1'b0, 4'h0);
    idle(2); #1;
    check_all_zero("midbyte_reset");
    rst = 1'b1;
    wr_nib(1'b0, 4'h2);
    check("post_reset_0x20", byte_data, 8'h20);
    check("post_reset_4bit", four_bit_mode, 1'b1);
    idle(BC + 5);

    for (int i = 0; i < 300; i++) begin
      logic       r_rs, r_rw;
      logic [3:0] r_nib;
      r_rs  = 1'($urandom_range(0, 1));
      r_rw  = ($urandom_range(0, 3) == 0);
      r_nib = 4'($urandom_range(0, 15));
      bus_cycle(r_rs, r_rw, r_nib, $urandom_range(3, 5), $urandom_range(3, 6), rd, oe);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 40));
    end

    idle(BL + 10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
